// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive front-end for the CPU peripheral bus.
//   Synchronises the asynchronous UART_RX pin and deserialises 8N1 frames
//   using 16x oversampling. Received bytes go into a small show-ahead FIFO
//   that the CPU drains. Framing and overrun faults are kept as sticky flags.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   UART_RX    serial line input, idle high, asynchronous to clk
//   rd_en      pop the FIFO head this cycle (ignored when empty)
//   clr_err    clears frame_err and overrun (a same-cycle set wins)
//   rx_data    FIFO head byte (show-ahead), 0 when empty
//   rx_empty   FIFO empty
//   rx_full    FIFO full
//   rx_count   FIFO occupancy
//   frame_err  sticky: stop bit sampled low
//   overrun    sticky: byte completed while FIFO full, byte dropped
//   rx_busy    receiver FSM is not idle
module uart_rx_fifo #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     UART_RX,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [7:0]               rx_data,
  output logic                     rx_empty,
  output logic                     rx_full,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     rx_busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  // Two-flop synchroniser; flops reset high so reset never looks like a start edge.
  logic sync1_q, sync2_q, rx_s;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= UART_RX;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // Receiver FSM, oversample tick and shift register.
  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       scnt_q, scnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tick, stop_ok, stop_bad;

  // The tick counter is parked at 0 in IDLE so each frame starts phase-aligned.
  assign tick = (state_q != S_IDLE) && (div_q == DIV_W'(DIV - 1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;

    if (state_q == S_IDLE || tick) div_d = '0;
    else                           div_d = div_q + DIV_W'(1);

    // scnt wraps 15 -> 0 naturally, which marks each 16-tick bit period.
    if (tick) scnt_d = scnt_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          scnt_d  = '0;
        end
      end
      S_START: begin
        if (tick && scnt_q == 4'd7) begin
          if (!rx_s) begin
            state_d = S_DATA;
            scnt_d  = '0;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;   // glitch shorter than half a bit
          end
        end
      end
      S_DATA: begin
        if (tick && scnt_q == 4'd15) begin
          shift_d = {rx_s, shift_q[7:1]};   // LSB arrives first
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tick && scnt_q == 4'd15) begin
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // Hold off until the line recovers so a break is not seen as new frames.
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      scnt_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      scnt_q  <= scnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Show-ahead FIFO and sticky error flags.
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic             full, pop, push, ovr_set;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop     = rd_en && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push    = stop_ok && (!full || pop);
  assign ovr_set = stop_ok && full && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    frame_err_d = frame_err_q;
    if (stop_bad)     frame_err_d = 1'b1;
    else if (clr_err) frame_err_d = 1'b0;

    overrun_d = overrun_q;
    if (ovr_set)      overrun_d = 1'b1;
    else if (clr_err) overrun_d = 1'b0;
  end

  // NOTE: storage has no reset; rx_data is masked to 0 while empty, so stale contents never show.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign rx_empty  = (count_q == '0);
  assign rx_full   = full;
  assign rx_count  = count_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo.
//   Drives 8N1 frames at 64 clk/bit (CLK_FREQ=6.4 MHz, BAUD=100 kbaud) and
//   compares the DUT against a transaction-level model: a byte queue plus
//   two sticky flag bits, updated once per whole frame / pop / clear.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 6400000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 4;
  localparam int BIT_CLK  = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       UART_RX = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty, rx_full, frame_err, overrun, rx_busy;
  logic [$clog2(DEPTH):0] rx_count;

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .UART_RX  (UART_RX),
    .rd_en    (rd_en),
    .clr_err  (clr_err),
    .rx_data  (rx_data),
    .rx_empty (rx_empty),
    .rx_full  (rx_full),
    .rx_count (rx_count),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int lat   = 0;

  // Reference model
  byte unsigned mq[$];
  logic m_ovr = 1'b0;
  logic m_ferr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    UART_RX = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Full frame; the line is left at the stop-bit level.
  task automatic send_byte(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_b);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop_b);
    if (!stop_b)                 m_ferr = 1'b1;
    else if (mq.size() < DEPTH)  mq.push_back(d);
    else                         m_ovr = 1'b1;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] head;
    head = (mq.size() != 0) ? mq[0] : 8'h00;
    check({tag, "_count"}, 32'(rx_count), 32'(mq.size()));
    check({tag, "_empty"}, 32'(rx_empty), 32'(mq.size() == 0));
    check({tag, "_full"},  32'(rx_full),  32'(mq.size() == DEPTH));
    check({tag, "_data"},  32'(rx_data),  32'(head));
    check({tag, "_ovr"},   32'(overrun),  32'(m_ovr));
    check({tag, "_ferr"},  32'(frame_err), 32'(m_ferr));
    check({tag, "_busy"},  32'(rx_busy),  32'(0));
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] head;
    head = (mq.size() != 0) ? mq[0] : 8'h00;
    check({tag, "_head"}, 32'(rx_data), 32'(head));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d, input logic stop_b);
    send_byte(d, stop_b);
    model_frame(d, stop_b);
    if (!stop_b) begin
      UART_RX = 1'b1;
      idle(4);
    end
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       sb;

    // Reset state, checked while reset is held.
    #3 reset = 1'b0;
    @(negedge clk);
    check_all("reset");
    idle(2);
    reset = 1'b1;
    idle(4);

    // Single byte 0xA5, with push latency measured from the start edge.
    fork
      send_byte(8'hA5, 1'b1);
      begin
        lat = 0;
        while (rx_empty && lat < 2000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    model_frame(8'hA5, 1'b1);
    check("a5_latency_window", 32'(lat >= 600 && lat <= 620), 32'(1));
    check_all("a5");
    pop_one("a5_pop");
    check_all("a5_after_pop");

    // Fill to full, then one overrun byte, then drain in order.
    frame(8'h00, 1'b1);
    frame(8'hFF, 1'b1);
    frame(8'h3C, 1'b1);
    frame(8'h81, 1'b1);
    check_all("fill4");
    frame(8'h55, 1'b1);
    check_all("overrun");
    for (int i = 0; i < 4; i++) pop_one("drain");
    check_all("drained");
    pop_one("pop_empty");
    check_all("pop_empty_after");
    clear_flags();
    check_all("clr_ovr");

    // Start-bit glitch of 20 clk.
    UART_RX = 1'b0;
    idle(5);
    check("glitch_busy", 32'(rx_busy), 32'(1));
    idle(15);
    UART_RX = 1'b1;
    idle(60);
    check_all("glitch");

    // Framing error followed by a held-low line.
    send_byte(8'h7E, 1'b0);
    model_frame(8'h7E, 1'b0);
    idle(200);
    check("break_busy", 32'(rx_busy), 32'(1));
    check("break_ferr", 32'(frame_err), 32'(1));
    check("break_count", 32'(rx_count), 32'(0));
    UART_RX = 1'b1;
    idle(4);
    check_all("break_release");
    frame(8'h12, 1'b1);
    check_all("after_break");
    clear_flags();
    check_all("clr_ferr");

    // Simultaneous pop and push on a full FIFO.
    while (mq.size() < DEPTH) frame(8'($urandom), 1'b1);
    check_all("full_again");
    fork
      send_byte(8'h99, 1'b1);
      begin
        // The stop bit is sampled on the 610th rising edge after the start edge.
        repeat (610) @(negedge clk);
        check("simul_busy", 32'(rx_busy), 32'(1));
        check("simul_head", 32'(rx_data), 32'(mq[0]));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    void'(mq.pop_front());
    mq.push_back(8'h99);
    check_all("simul");
    for (int i = 0; i < 4; i++) pop_one("simul_drain");
    check_all("simul_drained");

    // Reset in the middle of a data phase.
    frame(8'h5A, 1'b1);
    check_all("pre_reset");
    d = 8'h44;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    check("mid_busy", 32'(rx_busy), 32'(1));
    reset = 1'b0;
    #1;
    mq.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    check_all("mid_reset");
    UART_RX = 1'b1;
    @(negedge clk);
    idle(3);
    reset = 1'b1;
    idle(20);
    check_all("post_reset");
    frame(8'h66, 1'b1);
    check_all("after_reset_66");
    pop_one("pop_66");

    // Randomised traffic: random bytes, occasional bad stop bits, random
    // pops and flag clears between frames.
    for (int it = 0; it < 14; it++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) pop_one("rnd_pop");
      if ($urandom_range(0, 3) == 0) clear_flags();
      idle($urandom_range(1, 20));
      d  = 8'($urandom);
      sb = ($urandom_range(0, 5) != 0);
      frame(d, sb);
      check_all("rnd");
    end
    while (mq.size() != 0) pop_one("final_drain");
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
